ibex_nmi_bridge: RTL and testbench

Bridges the two OBI-style memory ports of the Ibex user core (instruction fetch and data load/store) onto the single `nmi_if.master` native memory port of the user core slot. It arbitrates between the two ports, keeps one transaction outstanding, and converts the req/gnt/rvalid protocol to the valid/ready protocol. A watchdog ends any native access that stalls, returning an error response. It sits between `ibex_top` and the `nmi` port inside `user_core_design`.

---
 rtl/ibex_nmi_bridge_if.sv | 18 +
 rtl/ibex_nmi_bridge.sv | 147 ++++++++++++++
 tb/tb_ibex_nmi_bridge.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_nmi_bridge_if.sv
// Native memory interface (nmi) of the user core slot.
//   valid/addr/wdata/wstrb : request, driven by the master
//   rdata/ready            : response, driven by the slave
interface nmi_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/ibex_nmi_bridge.sv
// Bridges the Ibex instruction and data OBI ports onto one native nmi port.
// One access is outstanding at a time; data wins over instr when both ask.
// A watchdog terminates an access after TIMEOUT stalled cycles with an error.
// Ports:
//   clk_i, rst_n_i                 : clock, async active-low reset
//   instr_req/gnt/rvalid/addr/rdata/err : Ibex fetch port
//   data_req/gnt/rvalid/we/be/addr/wdata/rdata/err : Ibex LSU port
//   nmi                            : native bus master (valid/ready)
module ibex_nmi_bridge #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  nmi_if.master       nmi
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic               src_q, src_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               instr_rvalid_q, instr_rvalid_d;
  logic               data_rvalid_q, data_rvalid_d;
  logic               timeout_c;

  // Watchdog fires on the T-th stalled cycle of valid; disabled when TIMEOUT is 0.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state, capture and combinational grant logic.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    instr_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          data_gnt_o = 1'b1;
          src_d      = 1'b1;
          addr_d     = data_addr_i & ~32'h3;
          wdata_d    = data_wdata_i;
          wstrb_d    = data_we_i ? data_be_i : 4'b0000;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (instr_req_i) begin
          instr_gnt_o = 1'b1;
          src_d       = 1'b0;
          addr_d      = instr_addr_i & ~32'h3;
          wdata_d     = '0;
          wstrb_d     = 4'b0000;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (nmi.ready) begin
          rdata_d        = nmi.rdata;
          err_d          = 1'b0;
          instr_rvalid_d = ~src_q;
          data_rvalid_d  = src_q;
          state_d        = IDLE;
        end else if (timeout_c) begin
          rdata_d        = '0;
          err_d          = 1'b1;
          instr_rvalid_d = ~src_q;
          data_rvalid_d  = src_q;
          state_d        = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      src_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      cnt_q          <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      cnt_q          <= cnt_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      instr_rvalid_q <= instr_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
    end
  end

  assign nmi.valid      = (state_q == BUSY);
  assign nmi.addr       = addr_q;
  assign nmi.wdata      = wdata_q;
  assign nmi.wstrb      = wstrb_q;

  // Both ports share the response registers; only the owner's rvalid pulses.
  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign data_err_o     = err_q;

endmodule

// File: tb/tb_ibex_nmi_bridge.sv
// Testbench for ibex_nmi_bridge: directed scenarios plus randomized accesses
// checked against a transaction-level model of grant/latency/response rules.
module tb_ibex_nmi_bridge;
  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;

  nmi_if nmi_bus ();

  ibex_nmi_bridge #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .nmi(nmi_bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by the slave model: a fixed scramble of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Slave: ready asserted in the (rdelay+1)-th cycle of valid.
  int          rdelay = 0;
  int          vcnt = 0;
  bit          force_ready = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  logic        ready_r = 1'b0;
  logic [31:0] rdata_r = 32'h0;
  assign nmi_bus.ready = ready_r;
  assign nmi_bus.rdata = rdata_r;

  always @(posedge clk) begin
    #1;
    if (nmi_bus.valid === 1'b1) vcnt++; else vcnt = 0;
    ready_r = force_ready || (nmi_bus.valid === 1'b1 && vcnt == rdelay + 1);
    rdata_r = ready_r ? (use_fixed ? fixed_rdata : mem_val(nmi_bus.addr)) : 32'($urandom);
  end

  // Monitor: responses, accepted bus accesses, and valid run lengths.
  typedef struct { int cyc; bit src; logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } acc_t;
  resp_t resp_q[$];
  acc_t  acc_q[$];
  int    len_q[$];
  int    run = 0;
  int    stab_err = 0;
  bit    prev_v = 1'b0;
  acc_t  cur;

  always @(negedge clk) begin
    if (instr_rvalid === 1'b1) resp_q.push_back(resp_t'{cyc, 1'b0, instr_rdata, instr_err});
    if (data_rvalid === 1'b1)  resp_q.push_back(resp_t'{cyc, 1'b1, data_rdata, data_err});
    if (nmi_bus.valid === 1'b1) begin
      if (!prev_v) begin
        cur = acc_t'{cyc, nmi_bus.addr, nmi_bus.wdata, nmi_bus.wstrb};
        acc_q.push_back(cur);
      end else if (nmi_bus.addr !== cur.addr || nmi_bus.wdata !== cur.wdata ||
                   nmi_bus.wstrb !== cur.wstrb) begin
        stab_err++;
      end
      run++;
    end else if (run > 0) begin
      len_q.push_back(run);
      run = 0;
    end
    prev_v = (nmi_bus.valid === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    resp_q.delete();
    acc_q.delete();
    len_q.delete();
  endtask

  // Drive one request and hold it until granted; returns grant cycle or -1.
  task automatic issue(input bit is_data, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, output int gcyc);
    gcyc = -1;
    if (is_data) begin
      data_req = 1'b1; data_addr = a; data_we = we; data_be = be; data_wdata = wd;
    end else begin
      instr_req = 1'b1; instr_addr = a;
    end
    for (int i = 0; i < 64 && gcyc < 0; i++) begin
      #1;
      if ((is_data ? data_gnt : instr_gnt) === 1'b1) gcyc = cyc;
      if (gcyc < 0) step();
    end
    step();
    instr_req = 1'b0; data_req = 1'b0;
    instr_addr = 32'($urandom); data_addr = 32'($urandom);
    data_wdata = 32'($urandom); data_be = 4'($urandom); data_we = 1'($urandom);
  endtask

  task automatic wait_resp(input int maxc);
    for (int i = 0; i < maxc && resp_q.size() == 0; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    n_total++;
    if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_err, data_err, nmi_bus.valid} !== 7'b0)
      $display("FAIL %s_ctrl got=%b exp=0000000", tag,
               {instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_err, data_err, nmi_bus.valid});
    else n_pass++;
    n_total++;
    if ({instr_rdata, data_rdata} !== 64'h0)
      $display("FAIL %s_rdata got=%h/%h exp=0", tag, instr_rdata, data_rdata);
    else n_pass++;
    n_total++;
    if ({nmi_bus.addr, nmi_bus.wdata, nmi_bus.wstrb} !== 68'h0)
      $display("FAIL %s_bus got=%h/%h/%h exp=0", tag, nmi_bus.addr, nmi_bus.wdata, nmi_bus.wstrb);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_reset_values("reset");
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    int g;
    clear_q(); rdelay = 1; use_fixed = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h3000_0002, 1'b0, 4'h0, 32'h0, g);
    wait_resp(20); step();
    use_fixed = 1'b0;
    n_total++;
    if (acc_q.size() != 1 || acc_q[0].addr !== 32'h3000_0000 || acc_q[0].wstrb !== 4'h0 || acc_q[0].cyc != g + 1)
      $display("FAIL fetch_bus got n=%0d addr=%h wstrb=%h exp n=1 addr=30000000 wstrb=0",
               acc_q.size(), acc_q[0].addr, acc_q[0].wstrb);
    else n_pass++;
    n_total++;
    if (resp_q.size() != 1 || resp_q[0].src !== 1'b0 || resp_q[0].cyc != g + 3)
      $display("FAIL fetch_rvalid got n=%0d src=%0d lat=%0d exp n=1 src=0 lat=3",
               resp_q.size(), resp_q[0].src, resp_q[0].cyc - g);
    else n_pass++;
    n_total++;
    if (resp_q[0].rdata !== 32'hDEAD_BEEF || resp_q[0].err !== 1'b0)
      $display("FAIL fetch_data got=%h err=%b exp=deadbeef err=0", resp_q[0].rdata, resp_q[0].err);
    else n_pass++;
  endtask

  task automatic test_byte_store();
    int g, d;
    clear_q(); d = $urandom_range(0, 3); rdelay = d;
    issue(1'b1, 32'h1000_0004, 1'b1, 4'b0100, 32'h00AB_0000, g);
    wait_resp(20); repeat (4) step();
    n_total++;
    if (acc_q.size() != 1 || acc_q[0].addr !== 32'h1000_0004 || acc_q[0].wstrb !== 4'b0100 ||
        acc_q[0].wdata !== 32'h00AB_0000)
      $display("FAIL store_bus got addr=%h wstrb=%b wdata=%h exp 10000004/0100/00ab0000",
               acc_q[0].addr, acc_q[0].wstrb, acc_q[0].wdata);
    else n_pass++;
    n_total++;
    if (resp_q.size() != 1 || resp_q[0].src !== 1'b1 || resp_q[0].cyc != g + d + 2)
      $display("FAIL store_rvalid got n=%0d src=%0d lat=%0d exp n=1 src=1 lat=%0d",
               resp_q.size(), resp_q[0].src, resp_q[0].cyc - g, d + 2);
    else n_pass++;
    n_total++;
    if (resp_q[0].rdata !== mem_val(32'h1000_0004) || resp_q[0].err !== 1'b0)
      $display("FAIL store_resp got=%h err=%b exp=%h err=0", resp_q[0].rdata, resp_q[0].err,
               mem_val(32'h1000_0004));
    else n_pass++;
  endtask

  task automatic test_contention();
    int gd, gi;
    clear_q(); rdelay = 2;
    data_req = 1'b1; data_addr = 32'h2000_0010; data_we = 1'b0; data_be = 4'hF;
    instr_req = 1'b1; instr_addr = 32'h4000_0008;
    #1;
    gd = cyc;
    n_total++;
    if ({data_gnt, instr_gnt} !== 2'b10)
      $display("FAIL contention_gnt got=%b exp=10", {data_gnt, instr_gnt});
    else n_pass++;
    step();
    data_req = 1'b0;
    gi = -1;
    for (int i = 0; i < 40 && gi < 0; i++) begin
      #1;
      if (instr_gnt === 1'b1) gi = cyc;
      if (gi < 0) step();
    end
    step();
    instr_req = 1'b0;
    for (int i = 0; i < 40 && resp_q.size() < 2; i++) step();
    step();
    n_total++;
    if (resp_q.size() != 2 || resp_q[0].src !== 1'b1 || resp_q[0].cyc != gd + 4 || resp_q[1].src !== 1'b0)
      $display("FAIL contention_order got n=%0d src0=%0d lat0=%0d exp n=2 src0=1 lat0=4",
               resp_q.size(), resp_q[0].src, resp_q[0].cyc - gd);
    else n_pass++;
    n_total++;
    if (gi != resp_q[0].cyc)
      $display("FAIL contention_igrant got=%0d exp=%0d", gi, resp_q[0].cyc);
    else n_pass++;
    n_total++;
    if (acc_q.size() != 2 || acc_q[0].addr !== 32'h2000_0010 || acc_q[1].addr !== 32'h4000_0008)
      $display("FAIL contention_bus got %h,%h exp 20000010,40000008", acc_q[0].addr, acc_q[1].addr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int g;
    clear_q(); rdelay = 1000;
    issue(1'b0, 32'h7000_0040, 1'b0, 4'h0, 32'h0, g);
    wait_resp(30); step();
    n_total++;
    if (resp_q.size() != 1 || resp_q[0].cyc != g + T + 1 || resp_q[0].err !== 1'b1 || resp_q[0].rdata !== 32'h0)
      $display("FAIL timeout_resp got n=%0d lat=%0d err=%b rdata=%h exp n=1 lat=%0d err=1 rdata=0",
               resp_q.size(), resp_q[0].cyc - g, resp_q[0].err, resp_q[0].rdata, T + 1);
    else n_pass++;
    n_total++;
    if (len_q.size() != 1 || len_q[0] != T)
      $display("FAIL timeout_len got=%0d exp=%0d", len_q[0], T);
    else n_pass++;
    resp_q.delete();
    force_ready = 1'b1; step(); step(); force_ready = 1'b0;
    repeat (4) step();
    n_total++;
    if (resp_q.size() != 0)
      $display("FAIL late_ready got=%0d rvalids exp=0", resp_q.size());
    else n_pass++;
    // Ready on the last allowed cycle is a normal completion.
    clear_q(); rdelay = T - 1;
    issue(1'b0, 32'h7000_0080, 1'b0, 4'h0, 32'h0, g);
    wait_resp(30); step();
    n_total++;
    if (resp_q.size() != 1 || resp_q[0].cyc != g + T + 1 || resp_q[0].err !== 1'b0 ||
        resp_q[0].rdata !== mem_val(32'h7000_0080))
      $display("FAIL edge_ready got lat=%0d err=%b rdata=%h exp lat=%0d err=0 rdata=%h",
               resp_q[0].cyc - g, resp_q[0].err, resp_q[0].rdata, T + 1, mem_val(32'h7000_0080));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int g;
    clear_q(); rdelay = 1000;
    issue(1'b0, 32'h5000_0000, 1'b0, 4'h0, 32'h0, g);
    step();
    n_total++;
    if (nmi_bus.valid !== 1'b1) $display("FAIL rstmid_busy got=%b exp=1", nmi_bus.valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    check_reset_values("rstmid");
    step(); step();
    rst_n = 1'b1;
    repeat (12) step();
    n_total++;
    if (resp_q.size() != 0) $display("FAIL rstmid_rvalid got=%0d exp=0", resp_q.size());
    else n_pass++;
    clear_q(); rdelay = 0;
    issue(1'b0, 32'h6000_000C, 1'b0, 4'h0, 32'h0, g);
    wait_resp(20); step();
    n_total++;
    if (resp_q.size() != 1 || resp_q[0].cyc != g + 2 || resp_q[0].err !== 1'b0 ||
        resp_q[0].rdata !== mem_val(32'h6000_000C))
      $display("FAIL rstmid_after got n=%0d lat=%0d rdata=%h exp n=1 lat=2 rdata=%h",
               resp_q.size(), resp_q[0].cyc - g, resp_q[0].rdata, mem_val(32'h6000_000C));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[16];
    int gc[16];
    int idx;
    clear_q(); rdelay = 0;
    for (int i = 0; i < 16; i++) addrs[i] = 32'($urandom);
    idx = 0;
    instr_req = 1'b1;
    for (int i = 0; i < 200 && idx < 16; i++) begin
      instr_addr = addrs[idx];
      #1;
      if (instr_gnt === 1'b1) begin
        gc[idx] = cyc;
        idx++;
      end
      step();
    end
    instr_req = 1'b0;
    for (int i = 0; i < 40 && resp_q.size() < 16; i++) step();
    step();
    n_total++;
    if (idx != 16 || resp_q.size() != 16 || acc_q.size() != 16)
      $display("FAIL b2b_count got gnt=%0d resp=%0d acc=%0d exp 16", idx, resp_q.size(), acc_q.size());
    else n_pass++;
    for (int i = 0; i < resp_q.size() && i < idx && i < acc_q.size(); i++) begin
      n_total++;
      if (resp_q[i].src !== 1'b0 || resp_q[i].cyc != gc[i] + 2 || resp_q[i].err !== 1'b0 ||
          resp_q[i].rdata !== mem_val(addrs[i] & ~32'h3) || acc_q[i].addr !== (addrs[i] & ~32'h3) ||
          (i > 0 && gc[i] - gc[i-1] != 2))
        $display("FAIL b2b_%0d got addr=%h rdata=%h lat=%0d exp addr=%h rdata=%h lat=2", i,
                 acc_q[i].addr, resp_q[i].rdata, resp_q[i].cyc - gc[i], addrs[i] & ~32'h3,
                 mem_val(addrs[i] & ~32'h3));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit          is_data, we, to;
    logic [3:0]  be, exp_wstrb;
    logic [31:0] a, wd, exp_addr, exp_rdata;
    int          d, g, k;
    for (int n = 0; n < 30; n++) begin
      is_data = 1'($urandom); we = 1'($urandom); be = 4'($urandom);
      a = 32'($urandom); wd = 32'($urandom); d = $urandom_range(0, 11);
      clear_q(); rdelay = d;
      issue(is_data, a, we, be, wd, g);
      wait_resp(30); step(); step();
      // Model: completes after d+1 valid cycles unless that exceeds T.
      to        = (d + 1 > T);
      k         = to ? T : d + 1;
      exp_addr  = a & ~32'h3;
      exp_wstrb = (is_data && we) ? be : 4'b0000;
      exp_rdata = to ? 32'h0 : mem_val(exp_addr);
      n_total++;
      if (g < 0 || resp_q.size() != 1 || resp_q[0].src !== is_data || resp_q[0].cyc != g + k + 1 ||
          resp_q[0].err !== to || resp_q[0].rdata !== exp_rdata)
        $display("FAIL rand%0d_resp got n=%0d src=%0d lat=%0d err=%b rdata=%h exp src=%0d lat=%0d err=%b rdata=%h",
                 n, resp_q.size(), resp_q[0].src, resp_q[0].cyc - g, resp_q[0].err, resp_q[0].rdata,
                 is_data, k + 1, to, exp_rdata);
      else n_pass++;
      n_total++;
      if (acc_q.size() != 1 || acc_q[0].addr !== exp_addr || acc_q[0].wstrb !== exp_wstrb ||
          (is_data && acc_q[0].wdata !== wd) || len_q.size() != 1 || len_q[0] != k)
        $display("FAIL rand%0d_bus got addr=%h wstrb=%b len=%0d exp addr=%h wstrb=%b len=%0d",
                 n, acc_q[0].addr, acc_q[0].wstrb, len_q[0], exp_addr, exp_wstrb, k);
      else n_pass++;
    end
  endtask

  initial begin
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    rst_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_byte_store();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_total++;
    if (stab_err != 0) $display("FAIL bus_stability got=%0d changes exp=0", stab_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
